// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with registered read data, occupancy count and level flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module param_sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       w_en,
  input  logic                       r_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // A flush cycle suppresses both operations so memory and data_out stay untouched.
  assign wr_acc = w_en && !full  && !clr;
  assign rd_acc = r_en && !empty && !clr;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset so it maps onto plain RAM; empty=1 hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: table-driven vectors with a queue scoreboard
// for read data, plus hand-written reset corner cases.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  param_sync_fifo #(
    .DATA_WIDTH(8), .DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int cnt);
    check({tag, " count"},        32'(count),        32'(cnt));
    check({tag, " full"},         32'(full),         32'(cnt == 8));
    check({tag, " empty"},        32'(empty),        32'(cnt == 0));
    check({tag, " almost_full"},  32'(almost_full),  32'(cnt >= 6));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    check({tag, " data_out"},     32'(data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check({tag, " overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, " underflow"},    32'(underflow),    32'(m_udf));
`endif
  endtask

  function automatic void add(input logic c, input logic w, input logic r,
                              input logic [7:0] d, input int cnt);
    vec_t v;
    v.c = c; v.w = w; v.r = r; v.d = d; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // Drive one cycle; the scoreboard decides acceptance from its own occupancy.
  task automatic step(input logic c, input logic w, input logic r,
                      input logic [7:0] d, input int cnt, input string tag);
    clr = c; w_en = w; r_en = r; data_in = d;
    if (c) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && sb.size() == 8) m_ovf = 1'b1;
      if (r && sb.size() == 0) m_udf = 1'b1;
      if (w && r && sb.size() > 0 && sb.size() < 8) begin
        m_dout = sb.pop_front();
        sb.push_back(d);
      end else if (r && sb.size() > 0) begin
        m_dout = sb.pop_front();
      end else if (w && sb.size() < 8) begin
        sb.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag, cnt);
  endtask

  initial begin
    // Write four, read four.
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'h11 + 8'(i), i + 1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h00, 3 - i);
    // Fill, then write while full.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h30 + 8'(i), i + 1);
    add(0, 1, 0, 8'hAA, 8);
    // Simultaneous request while full: read only.
    add(0, 1, 1, 8'h40, 7);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 8'h00, 6 - i);
    // Twelve simultaneous cycles at count 4 wrap both pointers.
    for (int i = 0; i < 12; i++) add(0, 1, 1, 8'h50 + 8'(i), 4);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h00, 3 - i);
    // Read while empty, then simultaneous while empty: write only.
    add(0, 0, 1, 8'h00, 0);
    add(0, 1, 1, 8'h20, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 8'h21 + 8'(i), i + 2);
    // Flush with a write pending, then refill two.
    add(1, 1, 0, 8'hEE, 0);
    add(0, 1, 0, 8'h60, 1);
    add(0, 1, 0, 8'h61, 2);

    // Initial asynchronous reset.
    #2 rst_n = 1'b0;
    #1 check_outputs("reset", 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].cnt,
           $sformatf("vec%0d", i));
    end
    clr = 1'b0; w_en = 1'b0; r_en = 1'b0;

    // Reset between edges must clear outputs without a clock.
    #3 rst_n = 1'b0;
    sb.delete();
    m_dout = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1 check_outputs("async_reset", 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset write lands at entry 0 and reads back alone.
    step(0, 1, 0, 8'h77, 1, "post_reset_wr");
    step(0, 0, 1, 8'h00, 0, "post_reset_rd");
    step(0, 0, 0, 8'h00, 0, "idle_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
